// File: rtl/mem_arb_pkg.sv
// Shared defaults and operation encoding for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned RD_LATENCY_DEF = 1;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the rotating pointer, wrapping upward.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    mask;
  logic [N-1:0]    masked_req;
  logic            found;

  always_comb begin
    mask       = '0;
    masked_req = '0;
    gnt        = '0;
    found      = 1'b0;
    ptr_d      = ptr_q;

    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr_q));
    end
    masked_req = req & mask;

    // Requests at or above the pointer win; otherwise fall back to the lowest index.
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && masked_req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end

    if (rst) begin
      gnt = '0;
    end

    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) begin
        ptr_d = (i == N - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between NUM_REQ requesters with round-robin
// arbitration, a registered command stage and a fixed-latency tagged read return.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]    rd_tag;

  // One-hot requester id per stage; all-zero means no read in flight.
  logic [NUM_REQ-1:0] tag_q [RD_LATENCY+1];
  logic [NUM_REQ-1:0] tag_d [RD_LATENCY+1];

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_tag      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr_d  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_d = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_wr_d    = (we[i] == OP_WR);
        mem_rd_d    = (we[i] == OP_RD);
        rd_tag[i]   = (we[i] == OP_RD);
      end
    end
  end

  always_comb begin
    tag_d[0] = rd_tag;
    for (int unsigned s = 1; s <= RD_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int unsigned s = 0; s <= RD_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int unsigned s = 0; s <= RD_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = tag_q[RD_LATENCY];
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant order, shadow memory, expected command and read returns).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 2;
  localparam int unsigned RL = 1;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR-1:0]    we;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic             mem_rd;
  logic             mem_wr;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  mem_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR),
    .RD_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h15) return 32'h0abcdefe;
    if (a == 'h20) return 32'h11112222;
    return 32'ha5000000 | (a * 32'h00010101);
  endfunction

  // Environment memory, one-cycle read latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int            cyc;
    logic [NR-1:0] id;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int            cyc;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_exp_t;

  rd_exp_t  rd_q[$];
  cmd_exp_t cmd_q[$];

  logic [DW-1:0] shadow [256];
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  int n_vec  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational grant, advance the model.
  task automatic step(input logic r, input logic [NR-1:0] rq, input logic [NR-1:0] w,
                      input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                      output logic [NR-1:0] g);
    logic [NR-1:0] exp_g;
    cmd_exp_t      c;
    @(negedge clk);
    rst = r; req = rq; we = w; addr = a; wdata = d;
    #1;
    exp_g = '0;
    if (!r) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (exp_g == '0 && rq[k]) exp_g[k] = 1'b1;
      end
    end
    check("gnt", 64'(gnt), 64'(exp_g));
    g = exp_g;
    if (r) begin
      m_ptr = 0; m_addr = '0; m_wdata = '0;
      rd_q.delete();
      c = '{cyc: cyc + 1, rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0};
    end else begin
      c = '{cyc: cyc + 1, rd: 1'b0, wr: 1'b0, addr: m_addr, wdata: m_wdata};
      for (int k = 0; k < NR; k++) begin
        if (exp_g[k]) begin
          m_ptr   = (k + 1) % NR;
          m_addr  = a[k*AW +: AW];
          m_wdata = d[k*DW +: DW];
          c.addr  = m_addr;
          c.wdata = m_wdata;
          if (w[k]) begin
            c.wr = 1'b1;
            shadow[m_addr] = m_wdata;
          end else begin
            c.rd = 1'b1;
            rd_q.push_back('{cyc: cyc + 1 + RL, id: exp_g, data: shadow[m_addr]});
          end
        end
      end
    end
    cmd_q.push_back(c);
  endtask

  // Monitor: compares the memory command and read return against the queues each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        logic [NR-1:0] exp_rv;
        if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
          cmd_exp_t c;
          c = cmd_q.pop_front();
          check("mem_rd", 64'(mem_rd), 64'(c.rd));
          check("mem_wr", 64'(mem_wr), 64'(c.wr));
          check("mem_addr", 64'(mem_addr), 64'(c.addr));
          check("mem_wdata", 64'(mem_wdata), 64'(c.wdata));
        end
        exp_rv = '0;
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) exp_rv = rd_q[0].id;
        check("rvalid", 64'(rvalid), 64'(exp_rv));
        if (exp_rv != '0) begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rdata", 64'(rdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    logic [NR-1:0]    g;
    logic [NR-1:0]    p_req, p_we;
    logic [NR*AW-1:0] p_addr;
    logic [NR*DW-1:0] p_data;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    m_ptr = 0; m_addr = '0; m_wdata = '0;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    // Reset with both requests held.
    repeat (3) step(1'b1, 2'b11, 2'b00, {8'h31, 8'h30}, {32'h1, 32'h0}, g);
    // Contention: alternating grants starting at requester 0.
    repeat (4) step(1'b0, 2'b11, 2'b00, {8'h31, 8'h30}, {32'h1, 32'h0}, g);
    // Idle, then a lone request from requester 1.
    repeat (5) step(1'b0, 2'b00, 2'b00, '0, '0, g);
    step(1'b0, 2'b10, 2'b10, {8'h40, 8'h00}, {32'h12345678, 32'h0}, g);
    // Write then read of the same address.
    step(1'b0, 2'b01, 2'b01, {8'h00, 8'h0a}, {32'h0, 32'hcafebabe}, g);
    step(1'b0, 2'b01, 2'b00, {8'h00, 8'h0a}, '0, g);
    // Interleaved reads on consecutive grants.
    step(1'b0, 2'b01, 2'b00, {8'h00, 8'h15}, '0, g);
    step(1'b0, 2'b10, 2'b00, {8'h20, 8'h00}, '0, g);
    repeat (2) step(1'b0, 2'b00, 2'b00, '0, '0, g);
    // Reset one cycle after a read grant.
    step(1'b0, 2'b01, 2'b00, {8'h00, 8'h15}, '0, g);
    step(1'b1, 2'b00, 2'b00, '0, '0, g);
    repeat (3) step(1'b0, 2'b00, 2'b00, '0, '0, g);

    // Randomized traffic; requests are held until granted.
    p_req = '0; p_we = '0; p_addr = '0; p_data = '0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      for (int k = 0; k < NR; k++) begin
        if (!p_req[k]) begin
          p_req[k] = ($urandom_range(0, 3) != 0);
          p_we[k]  = $urandom_range(0, 1) == 1;
          p_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
          p_data[k*DW +: DW] = $urandom;
        end
      end
      r = ($urandom_range(0, 59) == 0);
      step(r, p_req, p_we, p_addr, p_data, g);
      p_req = p_req & ~g;
    end
    repeat (6) step(1'b0, 2'b00, 2'b00, '0, '0, g);

    check("reads_outstanding", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-port synchronous memory (mem, one rd or wr per cycle) between NUM_REQ requesters. Each cycle it grants at most one requester, registers that requester's command onto the memory port, and returns read data with a per-requester valid strobe at fixed latency. It sits between client blocks and the mem instance and is the only driver of mem's rd/wr/addr/wdata.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 8, memory address width (256 locations)
NUM_REQ, 2, number of requesters (2..4)
RD_LATENCY, 1, cycles from mem rd sampled to mem rdata valid

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request, held until granted
we  in  NUM_REQ  per-requester op: 1=write, 0=read
addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
rvalid  out  NUM_REQ  one-hot read-data valid, one cycle wide
rdata  out  DATA_WIDTH  read data broadcast to all requesters, qualified by rvalid
mem_rd  out  1  registered read strobe to mem
mem_wr  out  1  registered write strobe to mem
mem_addr  out  ADDR_WIDTH  registered address to mem
mem_wdata  out  DATA_WIDTH  registered write data to mem
mem_rdata  in  DATA_WIDTH  read data from mem

Behaviour:
- Reset (rst=1 at posedge): rr pointer=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, read-tag pipeline cleared, so rvalid=0. gnt is forced to 0 while rst=1.
- Arbitration, cycle N: among asserted req, grant the first at or after the rr pointer, searching upward with wrap. Exactly one gnt bit is high if any req is high. gnt is never high without req.
- Pointer: on a grant to requester k, the pointer becomes (k+1) mod NUM_REQ at the next edge. With no grant, the pointer holds.
- Fairness: a continuously asserted req is granted within NUM_REQ cycles.
- Handshake: the transfer occurs when req[i] and gnt[i] are both high. The requester may change addr, wdata, we or drop req after that edge. Inputs are sampled only when granted.
- Command stage: the edge ending cycle N loads mem_addr, mem_wdata and mem_rd=~we[k], mem_wr=we[k]. With no grant, it loads mem_rd=0 and mem_wr=0, and addr/wdata hold. mem sees the command in cycle N+1.
- One operation per cycle. Back-to-back grants to the same or different requesters are allowed at full throughput.
- Read return: a tag (one-hot requester id plus valid) travels a shift pipeline of RD_LATENCY+1 stages. rvalid[k]=1 in exactly cycle N+1+RD_LATENCY, which is cycle N+2 for the default. rdata=mem_rdata combinationally. Writes produce no rvalid.
- Write then read of the same address in consecutive grants returns the new data, because mem orders them.
- Reset mid-operation: in-flight tags are dropped and no rvalid is produced afterward. A pending mem command is cancelled at the reset edge.
- Overlapping reads: tags are independent, so rvalid may be high on consecutive cycles for different requesters.

Decomposition:
- Shared package/header mem_arb_pkg: DATA_WIDTH/ADDR_WIDTH defaults, RD_LATENCY default, and the OP_RD/OP_WR encoding constants.
- Sub-module rr_arbiter: parameter N, inputs clk, rst, req[N-1:0], outputs one-hot gnt[N-1:0]. It holds the rr pointer and the masked/unmasked priority logic.
- Command register, tag pipeline and data routing stay in mem_arbiter.

Test Plan:
- Reset with req=2'b11 held: gnt=0, mem_rd=0, mem_wr=0, rvalid=0 throughout. After release, the first grant goes to requester 0.
- Single write then read: req0 writes 32'hcafebabe to addr 8'h0A in cycle N. mem_wr=1 and mem_addr=8'h0A in N+1. req0 reads 8'h0A in cycle N+1 -> rvalid=2'b01 and rdata=32'hcafebabe in cycle N+3.
- Contention: req=2'b11 held for 4 cycles -> gnt sequence 01,10,01,10, and mem addr alternates between req0 and req1 addresses.
- Interleaved reads: req0 reads 8'h15 (preloaded 32'h0abcdefe) and req1 reads 8'h20 (preloaded 32'h11112222) on consecutive grants -> rvalid=01 with 32'h0abcdefe, then next cycle rvalid=10 with 32'h11112222.
- Reset mid-read: grant a read in cycle N, assert rst in N+1 -> no rvalid in N+2, and all outputs are at reset values.
- Idle: req=0 for 5 cycles -> mem_rd=mem_wr=0, mem_addr unchanged, and the rr pointer unchanged (next single req1 is granted immediately).
